// File: rtl/bsg_async_fifo_rptr_ctrl.sv
//==============================================================================
// Module      : bsg_async_fifo_rptr_ctrl
// Description : Read-domain pointer controller for an async FIFO. Optional
//               sticky protocol checker enabled by BSG_ASYNC_FIFO_RPTR_ERR_CHECK_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module bsg_async_fifo_rptr_ctrl #(
    parameter int lg_size_p = 4
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic [lg_size_p:0]   w_ptr_gray_rsync_i,
    input  logic                 yumi_i,
    output logic                 valid_o,
    output logic [lg_size_p-1:0] r_addr_o,
    output logic [lg_size_p:0]   r_ptr_binary_o,
    output logic [lg_size_p:0]   r_ptr_gray_o,
    output logic [lg_size_p:0]   count_o,
    output logic                 err_o
);

    localparam int c_ptr_w = lg_size_p + 1;

    logic [c_ptr_w-1:0] r_bin;
    logic [c_ptr_w-1:0] r_gray;
    logic [c_ptr_w-1:0] r_count;
    logic [c_ptr_w-1:0] w_w_bin;
    logic [c_ptr_w-1:0] w_bin_next;
    logic [c_ptr_w-1:0] w_count_next;
    logic               w_valid;
    logic               w_deq;

    // Bit i of the binary value is the XOR of all gray bits at or above i.
    for (genvar i = 0; i < c_ptr_w; i++) begin : g_gray2bin
        assign w_w_bin[i] = ^(w_ptr_gray_rsync_i >> i);
    end

    // Gated by reset so the FIFO never looks non-empty while held in reset.
    assign w_valid      = reset_n_i & (r_gray != w_ptr_gray_rsync_i);
    assign w_deq        = yumi_i & w_valid;
    assign w_bin_next   = w_deq ? (r_bin + c_ptr_w'(1)) : r_bin;
    assign w_count_next = w_w_bin - w_bin_next;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_bin   <= '0;
            r_gray  <= '0;
            r_count <= '0;
        end else begin
            r_bin   <= w_bin_next;
            r_gray  <= w_bin_next ^ (w_bin_next >> 1);
            r_count <= w_count_next;
        end
    end

`ifdef BSG_ASYNC_FIFO_RPTR_ERR_CHECK_EN
    localparam logic [c_ptr_w-1:0] c_full = c_ptr_w'(1) << lg_size_p;

    logic r_err;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_err <= 1'b0;
        end else if ((yumi_i & ~w_valid) | (w_count_next > c_full)) begin
            r_err <= 1'b1;
        end
    end

    assign err_o = r_err;
`else
    assign err_o = 1'b0;
`endif

    assign valid_o        = w_valid;
    assign r_addr_o       = r_bin[lg_size_p-1:0];
    assign r_ptr_binary_o = r_bin;
    assign r_ptr_gray_o   = r_gray;
    assign count_o        = r_count;

endmodule

`default_nettype wire

// File: tb/tb_bsg_async_fifo_rptr_ctrl.sv
//==============================================================================
// Module      : tb_bsg_async_fifo_rptr_ctrl
// Description : Scoreboard bench for bsg_async_fifo_rptr_ctrl (lg_size_p = 4).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_bsg_async_fifo_rptr_ctrl;

`ifdef BSG_ASYNC_FIFO_RPTR_ERR_CHECK_EN
    localparam logic c_err_en = 1'b1;
`else
    localparam logic c_err_en = 1'b0;
`endif

    logic       clk_i;
    logic       reset_n_i;
    logic [4:0] w_ptr_gray_rsync_i;
    logic       yumi_i;
    logic       valid_o;
    logic [3:0] r_addr_o;
    logic [4:0] r_ptr_binary_o;
    logic [4:0] r_ptr_gray_o;
    logic [4:0] count_o;
    logic       err_o;

    bsg_async_fifo_rptr_ctrl #(.lg_size_p(4)) dut (
        .clk_i              (clk_i),
        .reset_n_i          (reset_n_i),
        .w_ptr_gray_rsync_i (w_ptr_gray_rsync_i),
        .yumi_i             (yumi_i),
        .valid_o            (valid_o),
        .r_addr_o           (r_addr_o),
        .r_ptr_binary_o     (r_ptr_binary_o),
        .r_ptr_gray_o       (r_ptr_gray_o),
        .count_o            (count_o),
        .err_o              (err_o)
    );

    typedef struct {
        int         cyc;
        string      name;
        logic       v;
        logic [4:0] bin;
        logic [4:0] gray;
        logic [4:0] cnt;
        logic       err;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_bad  = 0;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Monitor: compares every expectation scheduled for the current cycle.
    initial begin
        forever begin
            @(negedge clk_i);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                exp_t e;
                e = q.pop_front();
                n_vec++;
                if (e.cyc != cyc || valid_o !== e.v || r_ptr_binary_o !== e.bin ||
                    r_ptr_gray_o !== e.gray || r_addr_o !== e.bin[3:0] ||
                    count_o !== e.cnt || err_o !== e.err) begin
                    n_bad++;
                    $display("FAIL %s cyc=%0d: got v=%b bin=%0d gray=%b addr=%0d cnt=%0d err=%b, exp v=%b bin=%0d gray=%b addr=%0d cnt=%0d err=%b",
                             e.name, cyc, valid_o, r_ptr_binary_o, r_ptr_gray_o, r_addr_o, count_o, err_o,
                             e.v, e.bin, e.gray, e.bin[3:0], e.cnt, e.err);
                end
            end
        end
    end

    // Drive one cycle of inputs just after the edge and queue what must be seen this cycle.
    task automatic apply(input logic rst_n, input logic y, input logic [4:0] wg,
                         input logic ev, input logic [4:0] eb, input logic [4:0] eg,
                         input logic [4:0] ec, input logic ee, input string nm);
        exp_t e;
        @(posedge clk_i);
        #1;
        reset_n_i          = rst_n;
        yumi_i             = y;
        w_ptr_gray_rsync_i = wg;
        e.cyc = cyc; e.name = nm; e.v = ev; e.bin = eb; e.gray = eg; e.cnt = ec; e.err = ee;
        q.push_back(e);
    endtask

    task automatic release_reset();
        @(negedge clk_i);
        #1;
        reset_n_i = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, exp finish");
        $fatal(1);
    end

    initial begin
        reset_n_i          = 1'b0;
        yumi_i             = 1'b0;
        w_ptr_gray_rsync_i = 5'b00000;

        apply(0, 0, 5'b00000, 0, 0, 5'b00000, 0, 0, "reset");
        apply(0, 0, 5'b00001, 0, 0, 5'b00000, 0, 0, "reset_hold_gates_valid");
        release_reset();

        apply(1, 0, 5'b00001, 1, 0, 5'b00000, 1, 0, "single_valid");
        apply(1, 1, 5'b00001, 1, 0, 5'b00000, 1, 0, "single_yumi");
        apply(1, 0, 5'b00001, 0, 1, 5'b00001, 0, 0, "single_deq");

        apply(1, 0, 5'b00010, 1, 1, 5'b00001, 0, 0, "jump_valid");
        apply(1, 1, 5'b00010, 1, 1, 5'b00001, 2, 0, "jump_count2");
        apply(1, 1, 5'b00010, 1, 2, 5'b00011, 1, 0, "jump_count1");
        apply(1, 0, 5'b00010, 0, 3, 5'b00010, 0, 0, "jump_count0");

        apply(1, 1, 5'b00010, 0, 3, 5'b00010, 0, 0,        "illegal_yumi");
        apply(1, 0, 5'b00010, 0, 3, 5'b00010, 0, c_err_en, "err_set");
        apply(1, 0, 5'b00010, 0, 3, 5'b00010, 0, c_err_en, "err_sticky");

        // Write pointer at bin 19 against read bin 3: exactly full.
        apply(1, 0, 5'b11010, 1, 3, 5'b00010, 0,  c_err_en, "full_valid");
        apply(1, 0, 5'b11010, 1, 3, 5'b00010, 16, c_err_en, "full_count");
        for (int k = 0; k < 16; k++) begin
            logic [4:0] b;
            b = 5'(3 + k);
            apply(1, 1, 5'b11010, 1, b, b ^ (b >> 1), 5'(16 - k), c_err_en, "drain_offset");
        end
        apply(1, 0, 5'b11010, 0, 19, 5'b11010, 0, c_err_en, "full_drained");

        // Asynchronous reset in the middle of a cycle.
        apply(0, 0, 5'b11000, 0, 0, 5'b00000, 0, 0, "async_reset");
        apply(0, 0, 5'b11000, 0, 0, 5'b00000, 0, 0, "reset_held2");
        release_reset();

        apply(1, 0, 5'b11000, 1, 0, 5'b00000, 16, 0, "full_from_zero");
        for (int k = 0; k < 16; k++) begin
            logic [4:0] b;
            b = 5'(k);
            apply(1, 1, 5'b11000, 1, b, b ^ (b >> 1), 5'(16 - k), 0, "drain_zero");
        end
        apply(1, 0, 5'b11000, 0, 16, 5'b11000, 0, 0, "drained16");

        apply(1, 0, 5'b10000, 1, 16, 5'b11000, 0, 0, "w_to_31");
        for (int k = 0; k < 15; k++) begin
            logic [4:0] b;
            b = 5'(16 + k);
            apply(1, 1, 5'b10000, 1, b, b ^ (b >> 1), 5'(15 - k), 0, "drain_to_31");
        end
        apply(1, 0, 5'b10000, 0, 31, 5'b10000, 0, 0, "at31");
        apply(1, 0, 5'b00000, 1, 31, 5'b10000, 0, 0, "wrap_valid");
        apply(1, 1, 5'b00000, 1, 31, 5'b10000, 1, 0, "wrap_count");
        apply(1, 0, 5'b00000, 0, 0,  5'b00000, 0, 0, "wrap_done");

        repeat (3) @(negedge clk_i);
        #1;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending, exp 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
